// File: rtl/sw_led_pkg.sv
// Shared types and helpers for the switch-to-LED controller.
package sw_led_pkg;

    // Display mode applied to every switch channel.
    typedef enum logic [1:0] {
        MODE_FOLLOW = 2'd0,
        MODE_TOGGLE = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_INVERT = 2'd3
    } mode_e;

    // Minimum counter width; keeps a one-bit counter for tiny terminal counts.
    localparam int MIN_CNT_W = 1;

    // Bits needed to count 0..n-1, never fewer than MIN_CNT_W.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        if (w < MIN_CNT_W) begin
            w = MIN_CNT_W;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch channel: two-flop synchroniser, stability-counter debounce
// and rising-edge detect on the accepted level.
module sw_debounce
    import sw_led_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_raw,
    output logic sw_db,
    output logic rise
);

    localparam int             CW       = cnt_width(DEBOUNCE_CYC);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(DEBOUNCE_CYC - 32'sd1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(32'd1);
    localparam logic [CW-1:0]  CNT_ZERO = CW'(32'd0);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          db_q;
    logic          db_d;
    logic          prev_q;

    // Debounce decision: any return to the accepted level restarts the count.
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (sync2_q == db_q) begin
            cnt_d = CNT_ZERO;
            db_d  = db_q;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = CNT_ZERO;
            db_d  = sync2_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
            db_d  = db_q;
        end
    end

    // Synchroniser, debounce state and edge-detect history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= CNT_ZERO;
            db_q    <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sw_raw;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            prev_q  <= db_q;
        end
    end

    assign sw_db = db_q;
    // prev_q clears on reset, so a level held through reset yields one rise.
    assign rise  = db_q & ~prev_q;

endmodule

// File: rtl/sw_led_ctrl.sv
// Switch-to-LED controller: debounced switches drive LED groups in
// follow / toggle / blink / invert mode, with a shared free-running blink.
module sw_led_ctrl
    import sw_led_pkg::*;
#(
    parameter int N_SW           = 2,
    parameter int LEDS_PER_SW    = 2,
    parameter int DEBOUNCE_CYC   = 1_000_000,
    parameter int BLINK_HALF_CYC = 50_000_000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_SW-1:0]             sw,
    input  logic [1:0]                  mode,
    output logic [N_SW*LEDS_PER_SW-1:0] led,
    output logic [N_SW-1:0]             sw_db
);

    localparam int            BW        = cnt_width(BLINK_HALF_CYC);
    localparam logic [BW-1:0] BCNT_MAX  = BW'(BLINK_HALF_CYC - 32'sd1);
    localparam logic [BW-1:0] BCNT_ONE  = BW'(32'd1);
    localparam logic [BW-1:0] BCNT_ZERO = BW'(32'd0);

    logic [N_SW-1:0]             db_s;
    logic [N_SW-1:0]             rise_s;
    logic [N_SW-1:0]             grp_s;
    logic [N_SW-1:0]             tog_q;
    logic [N_SW-1:0]             tog_d;
    logic [BW-1:0]               bcnt_q;
    logic [BW-1:0]               bcnt_d;
    logic                        phase_q;
    logic                        phase_d;
    logic [N_SW*LEDS_PER_SW-1:0] led_q;
    logic [N_SW*LEDS_PER_SW-1:0] led_d;
    mode_e                       mode_s;

    for (genvar i = 0; i < N_SW; i++) begin : g_ch
        sw_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_debounce (
            .clk    (clk),
            .rst_n  (rst_n),
            .sw_raw (sw[i]),
            .sw_db  (db_s[i]),
            .rise   (rise_s[i])
        );
    end

    assign mode_s = mode_e'(mode);

    // Blink timebase: wrap at the half period and flip the shared phase.
    always_comb begin
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (bcnt_q == BCNT_MAX) begin
            bcnt_d  = BCNT_ZERO;
            phase_d = ~phase_q;
        end else begin
            bcnt_d  = bcnt_q + BCNT_ONE;
            phase_d = phase_q;
        end
    end

    // Toggle state flips on every accepted press, regardless of mode.
    always_comb begin
        tog_d = tog_q ^ rise_s;
    end

    // Per-channel display value for the current mode, fanned out to its LED group.
    always_comb begin
        grp_s = db_s;
        led_d = {(N_SW*LEDS_PER_SW){1'b0}};
        case (mode_s)
            MODE_FOLLOW: grp_s = db_s;
            MODE_TOGGLE: grp_s = tog_q;
            MODE_BLINK:  grp_s = db_s & {N_SW{phase_q}};
            MODE_INVERT: grp_s = ~db_s;
            default:     grp_s = db_s;
        endcase
        for (int i = 0; i < N_SW; i++) begin
            led_d[i*LEDS_PER_SW +: LEDS_PER_SW] = {LEDS_PER_SW{grp_s[i]}};
        end
    end

    // Blink counter, toggle flops and registered LED drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q  <= BCNT_ZERO;
            phase_q <= 1'b0;
            tog_q   <= {N_SW{1'b0}};
            led_q   <= {(N_SW*LEDS_PER_SW){1'b0}};
        end else begin
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            tog_q   <= tog_d;
            led_q   <= led_d;
        end
    end

    assign led   = led_q;
    assign sw_db = db_s;

endmodule

// File: tb/tb_sw_led_ctrl.sv
// Directed bench for sw_led_ctrl with a short debounce and blink period.
module tb_sw_led_ctrl;

    localparam logic [1:0] M_FOL = 2'd0;
    localparam logic [1:0] M_TOG = 2'd1;
    localparam logic [1:0] M_BLK = 2'd2;
    localparam logic [1:0] M_INV = 2'd3;

    logic       clk;
    logic       clk_run;
    logic       rst_n;
    logic [1:0] sw;
    logic [1:0] mode;
    logic [3:0] led;
    logic [1:0] sw_db;

    int checks;
    int errors;

    typedef struct {
        logic [1:0] sw;
        logic [1:0] mode;
        int         n;
        logic [3:0] led;
        logic [1:0] db;
    } vec_t;

    vec_t vecs [11];

    sw_led_ctrl #(
        .N_SW           (2),
        .LEDS_PER_SW    (2),
        .DEBOUNCE_CYC   (4),
        .BLINK_HALF_CYC (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw),
        .mode  (mode),
        .led   (led),
        .sw_db (sw_db)
    );

    initial clk = 1'b0;
    always #5 if (clk_run) clk = ~clk;

    task automatic step(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [3:0] led_exp, input logic [1:0] db_exp);
        checks++;
        if (led !== led_exp) begin
            errors++;
            $display("FAIL %s: led=%b expected %b", name, led, led_exp);
        end
        checks++;
        if (sw_db !== db_exp) begin
            errors++;
            $display("FAIL %s: sw_db=%b expected %b", name, sw_db, db_exp);
        end
    endtask

    // Asserts reset away from clock edges, checks the asynchronous clear,
    // then releases so that the next rising edge is the first sampling edge.
    task automatic do_reset(input logic [1:0] s, input logic [1:0] m);
        sw   = s;
        mode = m;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", 4'h0, 2'b00);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [13:0] bounce;
        logic [3:0]  exp_led;
        logic [1:0]  exp_db;
        int          m;

        checks  = 0;
        errors  = 0;
        clk_run = 1'b1;
        rst_n   = 1'b1;
        sw      = 2'b00;
        mode    = M_FOL;

        vecs[0]  = '{sw: 2'b00, mode: M_FOL, n: 32'd2, led: 4'b0000, db: 2'b00};
        vecs[1]  = '{sw: 2'b01, mode: M_FOL, n: 32'd5, led: 4'b0000, db: 2'b00};
        vecs[2]  = '{sw: 2'b01, mode: M_FOL, n: 32'd1, led: 4'b0000, db: 2'b01};
        vecs[3]  = '{sw: 2'b01, mode: M_FOL, n: 32'd1, led: 4'b0011, db: 2'b01};
        vecs[4]  = '{sw: 2'b01, mode: M_INV, n: 32'd1, led: 4'b1100, db: 2'b01};
        vecs[5]  = '{sw: 2'b01, mode: M_TOG, n: 32'd1, led: 4'b0011, db: 2'b01};
        vecs[6]  = '{sw: 2'b00, mode: M_FOL, n: 32'd5, led: 4'b0011, db: 2'b01};
        vecs[7]  = '{sw: 2'b00, mode: M_FOL, n: 32'd1, led: 4'b0011, db: 2'b00};
        vecs[8]  = '{sw: 2'b00, mode: M_FOL, n: 32'd1, led: 4'b0000, db: 2'b00};
        vecs[9]  = '{sw: 2'b00, mode: M_TOG, n: 32'd1, led: 4'b0011, db: 2'b00};
        vecs[10] = '{sw: 2'b00, mode: M_INV, n: 32'd1, led: 4'b1111, db: 2'b00};

        // Switches held high through reset: accepted 5 edges after the first sampling edge.
        do_reset(2'b11, M_FOL);
        for (int n = 1; n <= 5; n++) begin
            step(1);
            check($sformatf("rst_hold_e%0d", n), 4'h0, 2'b00);
        end
        step(1);
        check("rst_hold_db", 4'h0, 2'b11);
        step(1);
        check("rst_hold_led", 4'hF, 2'b11);

        // Table: follow latency, mode switching, toggle retention, invert.
        do_reset(2'b00, M_FOL);
        for (int i = 0; i < 11; i++) begin
            sw   = vecs[i].sw;
            mode = vecs[i].mode;
            step(vecs[i].n);
            check($sformatf("vec%0d", i), vecs[i].led, vecs[i].db);
        end

        // Bounce on sw[0]: high 3, low 2, high 3, low 6 -- never accepted.
        mode = M_FOL;
        step(1);
        check("bounce_pre", 4'h0, 2'b00);
        bounce = 14'b00000011100111;
        for (int i = 0; i < 14; i++) begin
            sw = {1'b0, bounce[i]};
            step(1);
            check($sformatf("bounce%0d", i), 4'h0, 2'b00);
        end
        // Counter is back at zero: a clean press needs the full interval again.
        sw = 2'b01;
        step(5);
        check("bounce_post_hold", 4'h0, 2'b00);
        step(1);
        check("bounce_post_acc", 4'h0, 2'b01);

        // Toggle: two clean presses on sw[1].
        do_reset(2'b00, M_TOG);
        sw = 2'b10;
        step(6);
        check("tog_p1_db", 4'h0, 2'b10);
        step(1);
        check("tog_p1_upd", 4'h0, 2'b10);
        step(1);
        check("tog_p1_led", 4'b1100, 2'b10);
        sw = 2'b00;
        step(8);
        check("tog_release", 4'b1100, 2'b00);
        sw = 2'b10;
        step(7);
        check("tog_p2_hold", 4'b1100, 2'b10);
        step(1);
        check("tog_p2_led", 4'b0000, 2'b10);

        // Rise on sw[0] and switch to TOGGLE in the same cycle.
        mode = M_FOL;
        sw   = 2'b11;
        step(5);
        check("sim_pre", 4'b1100, 2'b10);
        step(1);
        check("sim_acc", 4'b1100, 2'b11);
        mode = M_TOG;
        step(1);
        check("sim_old_tog", 4'b0000, 2'b11);
        step(1);
        check("sim_new_tog", 4'b0011, 2'b11);

        // Blink: phase flips every 8 edges from reset; led follows one edge later.
        do_reset(2'b01, M_BLK);
        for (int n = 1; n <= 40; n++) begin
            step(1);
            m       = n - 1;
            exp_led = ((m >= 6) && (((m / 8) % 2) == 1)) ? 4'b0011 : 4'b0000;
            exp_db  = (n >= 6) ? 2'b01 : 2'b00;
            check($sformatf("blink_e%0d", n), exp_led, exp_db);
        end
        sw = 2'b00;
        step(7);
        check("blink_off", 4'h0, 2'b00);
        mode = M_INV;
        step(1);
        check("invert_zero", 4'hF, 2'b00);

        // Asynchronous reset with the clock stopped, toggle state 11.
        do_reset(2'b11, M_TOG);
        step(8);
        check("stop_pre", 4'hF, 2'b11);
        clk_run = 1'b0;
        #20;
        rst_n = 1'b0;
        #1;
        check("stop_async", 4'h0, 2'b00);
        sw = 2'b00;
        #10;
        rst_n = 1'b1;
        #10;
        check("stop_released", 4'h0, 2'b00);
        clk_run = 1'b1;
        step(10);
        check("stop_after", 4'h0, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
